// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the parametrised FIFO family.
// Pure functions only; no logic, no latency, no flow control.
package fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; read is combinational; no flow control of its own.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy, thresholds, sticky errors and optional FWFT read.
// Read latency 1 cycle (0 in FWFT); writes refused while full, reads refused while empty.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write_valid,
  input  logic [DATA_W-1:0]         write_data,
  output logic                      write_success,
  output logic                      write_full,
  input  logic                      read_valid,
  output logic [DATA_W-1:0]         read_data,
  output logic                      read_success,
  output logic                      read_empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_TH out of range 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_TH out of range 0..DEPTH-1");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ws_q, ws_d, rs_q, rs_d;
  logic              ov_q, ov_d, un_q, un_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Flags come straight from the registered count so acceptance never sees same-cycle traffic.
  assign write_full   = (count_q == DEPTH_C);
  assign read_empty   = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  always_comb begin
    wr_acc   = write_valid && !write_full;
    rd_acc   = read_valid && !read_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_rdata;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ws_d = wr_acc;
    rs_d = rd_acc;
    // A new error in the clearing cycle takes priority over clr_err.
    ov_d = (write_valid && write_full) || (ov_q && !clr_err);
    un_d = (read_valid && read_empty) || (un_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      ws_q     <= 1'b0;
      rs_q     <= 1'b0;
      ov_q     <= 1'b0;
      un_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      ws_q     <= ws_d;
      rs_q     <= rs_d;
      ov_q     <= ov_d;
      un_q     <= un_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (write_data),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  assign read_data     = (FWFT != 0) ? mem_rdata : rdata_q;
  assign write_success = ws_q;
  assign read_success  = rs_q;
  assign count         = count_q;
  assign overflow      = ov_q;
  assign underflow     = un_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read and FWFT instances share stimulus and a queue model.
module tb_sync_fifo_param;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wv = 1'b0, rv = 1'b0, clr = 1'b0;
  logic [DW-1:0] wd = '0;

  logic [DW-1:0] o0_rdata, o1_rdata;
  logic [CW-1:0] o0_count, o1_count;
  logic o0_ws, o0_full, o0_rs, o0_empty, o0_af, o0_ae, o0_ov, o0_un;
  logic o1_ws, o1_full, o1_rs, o1_empty, o1_af, o1_ae, o1_ov, o1_un;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .write_valid(wv), .write_data(wd),
    .write_success(o0_ws), .write_full(o0_full), .read_valid(rv),
    .read_data(o0_rdata), .read_success(o0_rs), .read_empty(o0_empty),
    .almost_full(o0_af), .almost_empty(o0_ae), .count(o0_count),
    .overflow(o0_ov), .underflow(o0_un), .clr_err(clr));

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .write_valid(wv), .write_data(wd),
    .write_success(o1_ws), .write_full(o1_full), .read_valid(rv),
    .read_data(o1_rdata), .read_success(o1_rs), .read_empty(o1_empty),
    .almost_full(o1_af), .almost_empty(o1_ae), .count(o1_count),
    .overflow(o1_ov), .underflow(o1_un), .clr_err(clr));

  int n_chk = 0;
  int n_err = 0;

  // Reference state: contents as a queue, plus the expected registered outputs.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rd;
  logic m_ws, m_rs, m_ov, m_un;
  bit   started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    bit wa, ra, full, empty;
    logic [DW-1:0] head;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        exp_q.delete();
        m_rd = '0; m_ws = 0; m_rs = 0; m_ov = 0; m_un = 0;
        started = 1;
      end else if (started) begin
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        wa = wv && !full;
        ra = rv && !empty;
        m_ov = (wv && full) ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_un = (rv && empty) ? 1'b1 : (clr ? 1'b0 : m_un);
        if (ra) begin
          head = mq.pop_front();
          exp_q.push_back(head);
          m_rd = head;
        end
        if (wa) mq.push_back(wd);
        m_ws = wa;
        m_rs = ra;
      end
    end
  end

  initial begin : monitor
    logic [DW-1:0] e;
    int sz;
    forever begin
      @(negedge clk);
      if (started) begin
        sz = mq.size();
        chk("count0", 32'(o0_count), 32'(sz));
        chk("count1", 32'(o1_count), 32'(sz));
        chk("full", 32'({o0_full, o1_full}), {2{sz == DEPTH}});
        chk("empty", 32'({o0_empty, o1_empty}), {2{sz == 0}});
        chk("afull", 32'({o0_af, o1_af}), {2{sz >= AF_TH}});
        chk("aempty", 32'({o0_ae, o1_ae}), {2{sz <= AE_TH}});
        chk("wr_success", 32'({o0_ws, o1_ws}), {2{m_ws}});
        chk("rd_success", 32'({o0_rs, o1_rs}), {2{m_rs}});
        chk("overflow", 32'({o0_ov, o1_ov}), {2{m_ov}});
        chk("underflow", 32'({o0_un, o1_un}), {2{m_un}});
        chk("rd_hold", 32'(o0_rdata), 32'(m_rd));
        if (o0_rs) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_pop: read_success with no expected word at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data", 32'(o0_rdata), 32'(e));
          end
        end
        if (!o1_empty && sz > 0) chk("fwft_head", 32'(o1_rdata), 32'(mq[0]));
      end
    end
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic c, input logic rn);
    wv = w; wd = d; rv = r; clr = c; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int wprob;
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h11, 0, 0, 1);
    cyc(1, 8'h22, 0, 0, 1);
    cyc(1, 8'h33, 0, 0, 1);
    cyc(1, 8'h44, 0, 0, 1);
    cyc(1, 8'h55, 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    cyc(1, 8'hA0, 0, 0, 1);
    cyc(1, 8'hB0, 0, 0, 1);
    cyc(1, 8'hC0, 1, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 2; i++) cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    cyc(1, 8'hD0, 1, 0, 1);
    cyc(0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 10; i++) cyc(1, 8'(i), (i > 0), 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'h5A, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 8'hE0 + 8'(i), 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    wprob = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) wprob = (i / 100 % 3 == 0) ? 80 : ((i / 100 % 3 == 1) ? 20 : 50);
      cyc($urandom_range(0, 99) < wprob, 8'($urandom), $urandom_range(0, 99) < 50,
          $urandom_range(0, 19) == 0, $urandom_range(0, 199) != 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 0, 1);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; next generation of the team's 8-bit FIFO.
- Adds configurable width and depth, an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer blocks in the same clock domain as the generic elastic buffer.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=2
AFULL_TH, DEPTH-2, almost_full asserted when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = head word visible on read_data without a read

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
write_valid  in  1  write request
write_data  in  DATA_W  data to write
write_success  out  1  registered one-cycle pulse; previous-cycle write accepted
write_full  out  1  count == DEPTH
read_valid  in  1  read request
read_data  out  DATA_W  read data
read_success  out  1  registered one-cycle pulse; previous-cycle read accepted
read_empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; write attempted while full
underflow  out  1  sticky; read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- One clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk only.
- Reset values:
  - wr_ptr, rd_ptr and count = 0; read_data = 0.
  - read_success, write_success = 0.
  - read_empty = 1, write_full = 0, almost_empty = 1, almost_full = 0.
  - overflow, underflow = 0.
  - Memory contents are not reset.
- Reset mid-operation: all stored words are discarded. Outputs take reset values on the edge where rst_n is low, then hold them until the first edge with rst_n high.
- Write accept: wr_acc = write_valid && !write_full. It is evaluated on the registered flags, so a write on a full FIFO is rejected even if a read is accepted in the same cycle.
- Read accept: rd_acc = read_valid && !read_empty. A read on an empty FIFO is rejected even if a write is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= write_data; wr_ptr increments modulo DEPTH, with natural wrap.
- On rd_acc: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both are accepted or neither is.
  - Never exceeds DEPTH and never underflows.
- All status flags are derived from the registered count and are valid in the cycle after the edge that changes count.
- write_success = registered wr_acc; read_success = registered rd_acc. Each is high for exactly one cycle per accepted op.
- FWFT=0:
  - read_data <= mem[rd_ptr] on rd_acc; data is valid in the same cycle read_success is high.
  - read_data holds its value otherwise. Read latency is 1 cycle.
- FWFT=1:
  - read_data = mem[rd_ptr] combinationally; valid whenever read_empty = 0.
  - rd_acc consumes the head word; read_success still pulses one cycle later.
  - read_data is don't-care while empty.
- Write to a full FIFO: data is dropped, no pointer or count change, write_success = 0, overflow <= 1.
- Read from an empty FIFO: no change, read_data holds, read_success = 0, underflow <= 1.
- clr_err = 1 clears overflow and underflow on the next edge. If a new error occurs in the same cycle, the set wins.
- Elaboration: an illegal DEPTH (not a power of 2, or <2) or thresholds out of range cause an elaboration-time $error.

Decomposition:
- Package fifo_pkg holds:
  - function cnt_w(depth) = $clog2(depth)+1
  - localparam-friendly check function is_pow2
- Natural sub-module fifo_mem:
  - DEPTH x DATA_W simple dual-port array, one write port, one asynchronous read port.
  - The FWFT=0 output register lives in sync_fifo_param.

Test Plan:
- DEPTH=4, DATA_W=8, FWFT=0. After reset, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles:
  - write_success pulses 4 times; count = 4, write_full = 1, almost_full = 1 (AFULL_TH=2 at count >= 2).
  - A 5th write of 0x55 sets overflow = 1 and count stays 4.
- Then read 4 times:
  - read_data = 0x11, 0x22, 0x33, 0x44, each with read_success = 1 one cycle after its request.
  - Ends with read_empty = 1, count = 0.
  - A 5th read sets underflow = 1 and read_data holds 0x44.
- Simultaneous write and read at count = 2 (head 0xA0): count stays 2; read_data = 0xA0 next cycle.
  - Simultaneous write+read at count = 0: only the write is accepted, count = 1, underflow = 1.
- Pointer wrap: stream 10 writes interleaved with reads, values 0x00..0x09. Read order is exactly 0x00..0x09 and count is never > 4.
- FWFT=1: write 0x5A into an empty FIFO. The cycle after, read_data = 0x5A with read_empty = 0 and no read issued. Read it: read_empty = 1, read_success pulses.
- Set overflow, then assert clr_err with no error that cycle → overflow = 0. Assert rst_n = 0 at count = 3 for one cycle → all outputs at reset values the next cycle and prior data is not readable.
